// File: rtl/dso_pkg.sv
// Shared scope definitions: slave-select targets and the SPI
// scheduler FSM state encoding.
package dso_pkg;

   localparam int SS_EEPROM  = 0;
   localparam int SS_CH1     = 1;
   localparam int SS_CH2     = 2;
   localparam int SS_CH3     = 3;
   localparam int SS_TRIGGER = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_GAP    = 2'd3
   } ss_state_e;

endpackage

// File: rtl/ss_req_fifo.sv
// Request queue for the SPI slave-select scheduler. A push while full
// is taken when a pop happens on the same edge.
module ss_req_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_rdata = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_wdata;
   end

endmodule

// File: rtl/spi_ss_sched.sv
// SPI slave-select scheduler: queues requests, launches them one at a time
// with an idle gap. Define SPI_SS_SCHED_TIMEOUT_EN for a WAIT watchdog.
module spi_ss_sched
   import dso_pkg::*;
#(
   parameter int NUM_SS      = 5,
   parameter int DATA_W      = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int GAP_CYC     = 8,
   parameter int TIMEOUT_CYC = 1024,
   localparam int SSW        = $clog2(NUM_SS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic [SSW-1:0]    req_ss,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_vld,
   output logic [SSW-1:0]    rsp_ss,
   output logic [DATA_W-1:0] rsp_data,
   output logic              spi_wrt,
   output logic [DATA_W-1:0] spi_cmd,
   input  logic              spi_ss_n,
   input  logic              spi_done,
   input  logic [DATA_W-1:0] spi_rdata,
   output logic [NUM_SS-1:0] ss_n,
   output logic              busy,
   output logic              err
);

   localparam int GW = $clog2(GAP_CYC + 1);
   localparam int EW = SSW + DATA_W;

   ss_state_e         r_state;
   logic [SSW-1:0]    r_sel;
   logic [DATA_W-1:0] r_cmd;
   logic              r_wrt;
   logic              r_rsp_vld;
   logic [SSW-1:0]    r_rsp_ss;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_ssn_q;
   logic              r_err;
   logic [GW-1:0]     r_gap;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [EW-1:0]     w_head;
   logic [SSW-1:0]    w_head_ss;
   logic [DATA_W-1:0] w_head_data;
   logic              w_bad;
   logic [NUM_SS-1:0] w_ss_n;

   assign w_push      = req_vld && !w_full;
   assign w_pop       = (r_state == ST_LAUNCH);
   assign w_head_ss   = w_head[EW-1 -: SSW];
   assign w_head_data = w_head[DATA_W-1:0];
   assign w_bad       = ({1'b0, w_head_ss} >= (SSW+1)'(NUM_SS));

   ss_req_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata ({req_ss, req_data}),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef SPI_SS_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_to;
   logic          w_to;

   assign w_to = (r_to == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || r_state != ST_WAIT)
         r_to <= '0;
      else
         r_to <= r_to + 1'b1;
   end
`else
   logic w_unused_to;
   assign w_unused_to = (TIMEOUT_CYC != 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_cmd      <= '0;
         r_wrt      <= 1'b0;
         r_rsp_vld  <= 1'b0;
         r_rsp_ss   <= '0;
         r_rsp_data <= '0;
         r_ssn_q    <= 1'b1;
         r_err      <= 1'b0;
         r_gap      <= '0;
      end else begin
         r_wrt     <= 1'b0;
         r_rsp_vld <= 1'b0;
         r_ssn_q   <= spi_ss_n;
         unique case (r_state)
            ST_IDLE: begin
               if (!w_empty) r_state <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
               // Out-of-range targets are dropped without touching the bus
               if (w_bad) begin
                  r_err   <= 1'b1;
                  r_state <= ST_GAP;
               end else begin
                  r_sel   <= w_head_ss;
                  r_cmd   <= w_head_data;
                  r_wrt   <= 1'b1;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (spi_done) begin
                  r_rsp_vld  <= 1'b1;
                  r_rsp_ss   <= r_sel;
                  r_rsp_data <= spi_rdata;
                  r_state    <= ST_GAP;
               end
`ifdef SPI_SS_SCHED_TIMEOUT_EN
               else if (w_to) begin
                  r_err   <= 1'b1;
                  r_state <= ST_GAP;
               end
`endif
            end
            ST_GAP: begin
               if (r_gap == GW'(GAP_CYC - 1)) begin
                  r_gap   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Only the latched target follows the master; the rest stay deselected
   always_comb begin
      w_ss_n = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (r_sel == SSW'(i)) w_ss_n[i] = r_ssn_q;
      end
   end

   assign ss_n     = w_ss_n;
   assign req_rdy  = !w_full;
   assign busy     = (r_state != ST_IDLE) || !w_empty;
   assign err      = r_err;
   assign spi_wrt  = r_wrt;
   assign spi_cmd  = r_cmd;
   assign rsp_vld  = r_rsp_vld;
   assign rsp_ss   = r_rsp_ss;
   assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_spi_ss_sched.sv
// Directed bench for spi_ss_sched with an SPI master model and
// launch/response scoreboards.
module tb_spi_ss_sched;
   import dso_pkg::*;

   localparam int NSS = 5;
   localparam int DW  = 16;
   localparam int GAP = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_vld;
   logic          req_rdy;
   logic [2:0]    req_ss;
   logic [DW-1:0] req_data;
   logic          rsp_vld;
   logic [2:0]    rsp_ss;
   logic [DW-1:0] rsp_data;
   logic          spi_wrt;
   logic [DW-1:0] spi_cmd;
   logic          spi_ss_n;
   logic          spi_done;
   logic [DW-1:0] spi_rdata;
   logic [NSS-1:0] ss_n;
   logic          busy;
   logic          err;

   always #5 clk = ~clk;

   spi_ss_sched #(
      .NUM_SS      (NSS),
      .DATA_W      (DW),
      .FIFO_DEPTH  (4),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .req_ss    (req_ss),
      .req_data  (req_data),
      .rsp_vld   (rsp_vld),
      .rsp_ss    (rsp_ss),
      .rsp_data  (rsp_data),
      .spi_wrt   (spi_wrt),
      .spi_cmd   (spi_cmd),
      .spi_ss_n  (spi_ss_n),
      .spi_done  (spi_done),
      .spi_rdata (spi_rdata),
      .ss_n      (ss_n),
      .busy      (busy),
      .err       (err)
   );

   typedef struct packed {
      logic [2:0]    ss;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q_launch[$];
   ent_t q_rsp[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_rsp = 0;
   int   cyc = 0;
   int   last_done = -1000;
   int   mdl_lat = 10;
   bit   mdl_en = 1'b0;
   bit   mdl_busy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] ss, input logic [DW-1:0] d,
                       input bit good);
      int b = 0;
      @(negedge clk);
      req_vld = 1'b1;
      req_ss = ss;
      req_data = d;
      while (!req_rdy && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (!req_rdy) chk("push_rdy", req_rdy, 1);
      @(posedge clk);
      if (good) q_launch.push_back({ss, d});
      #1 req_vld = 1'b0;
   endtask

   task automatic wait_wrt();
      int b = 0;
      while (!spi_wrt && b < 20) begin
         @(negedge clk);
         b++;
      end
      chk("wrt_seen", spi_wrt, 1);
   endtask

   task automatic wait_idle();
      int b = 0;
      @(negedge clk);
      while ((busy || mdl_busy || q_launch.size() != 0) && b < 1000) begin
         @(negedge clk);
         b++;
      end
      chk("idle_busy", busy, 0);
      chk("idle_launch_left", q_launch.size(), 0);
   endtask

   // SPI master model: answers each launch, rdata = cmd ^ A53C
   initial begin : mdl
      ent_t e;
      logic [DW-1:0] rd;
      logic [NSS-1:0] msk;
      forever begin
         @(negedge clk);
         if (mdl_en && spi_wrt) begin
            mdl_busy = 1'b1;
            e = '0;
            if (q_launch.size() == 0) begin
               chk("launch_unexp", spi_wrt, 0);
            end else begin
               e = q_launch.pop_front();
               chk("launch_cmd", spi_cmd, e.d);
               chk("launch_gap", (cyc - last_done >= GAP), 1);
            end
            spi_ss_n = 1'b0;
            @(negedge clk);
            msk = ~(NSS'(1) << e.ss);
            chk("ss_n_sel", ss_n, msk);
            repeat (mdl_lat - 1) @(negedge clk);
            rd = e.d ^ 16'hA53C;
            spi_done = 1'b1;
            spi_rdata = rd;
            q_rsp.push_back({e.ss, rd});
            last_done = cyc + 1;
            @(negedge clk);
            spi_done = 1'b0;
            spi_ss_n = 1'b1;
            mdl_busy = 1'b0;
         end
      end
   end

   initial begin : mon
      ent_t r;
      forever begin
         @(negedge clk);
         if (rsp_vld) begin
            if (q_rsp.size() == 0) begin
               chk("rsp_unexp", rsp_vld, 0);
            end else begin
               r = q_rsp.pop_front();
               chk("rsp_ss", rsp_ss, r.ss);
               chk("rsp_data", rsp_data, r.d);
               n_rsp++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_vld = 1'b0;
      req_ss = '0;
      req_data = '0;
      spi_ss_n = 1'b1;
      spi_done = 1'b0;
      spi_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", ss_n, 5'b11111);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_wrt", spi_wrt, 0);
      chk("rst_cmd", spi_cmd, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp_data", rsp_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", req_rdy, 1);

      // single request, two-cycle launch latency
      mdl_en = 1'b1;
      push(3'(SS_CH2), 16'hA5C3, 1'b1);
      @(negedge clk);
      chk("lat_c1", spi_wrt, 0);
      @(negedge clk);
      chk("lat_c2", spi_wrt, 0);
      @(negedge clk);
      chk("lat_c3", spi_wrt, 1);
      chk("lat_cmd", spi_cmd, 16'hA5C3);
      wait_idle();
      chk("n_rsp_single", n_rsp, 1);
      chk("err_clean", err, 0);

      // burst of five: one in WAIT, four queued
      push(3'(SS_EEPROM), 16'h1111, 1'b1);
      wait_wrt();
      push(3'(SS_CH1), 16'h2222, 1'b1);
      push(3'(SS_CH3), 16'h3333, 1'b1);
      push(3'(SS_TRIGGER), 16'h4444, 1'b1);
      push(3'(SS_CH2), 16'h5555, 1'b1);
      @(negedge clk);
      chk("burst_rdy_full", req_rdy, 0);
      chk("burst_busy", busy, 1);
      wait_idle();
      chk("n_rsp_burst", n_rsp, 6);
      chk("burst_rdy_back", req_rdy, 1);

      // invalid target then a valid one
      push(3'd6, 16'hDEAD, 1'b0);
      push(3'(SS_TRIGGER), 16'hBEEF, 1'b1);
      wait_idle();
      chk("bad_err", err, 1);
      chk("n_rsp_bad", n_rsp, 7);

      // reset in WAIT flushes queue and drops the response
      mdl_en = 1'b0;
      push(3'(SS_CH1), 16'h0F0F, 1'b0);
      push(3'(SS_CH3), 16'h7777, 1'b0);
      wait_wrt();
      spi_ss_n = 1'b0;
      @(negedge clk);
      chk("wait_ss_n", ss_n, 5'b11101);
      chk("err_sticky", err, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ss_n", ss_n, 5'b11111);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rdy", req_rdy, 1);
      chk("mid_rst_err", err, 0);
      spi_ss_n = 1'b1;
      spi_done = 1'b1;
      spi_rdata = 16'hCAFE;
      @(negedge clk);
      spi_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", rsp_vld, 0);
         chk("mid_rst_no_wrt", spi_wrt, 0);
      end
      chk("mid_rst_idle", busy, 0);

`ifdef SPI_SS_SCHED_TIMEOUT_EN
      push(3'(SS_CH3), 16'h9999, 1'b0);
      wait_wrt();
      repeat (15) @(negedge clk);
      chk("to_err_early", err, 0);
      @(negedge clk);
      chk("to_err", err, 1);
      chk("to_busy_gap", busy, 1);
      wait_idle();
      chk("to_ss_n", ss_n, 5'b11111);
`endif

      chk("end_rsp_left", q_rsp.size(), 0);
      chk("end_n_rsp", n_rsp, 7);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_ss_sched.md
SPI_SS_SCHED -- requirements
Module: spi_ss_sched

Interface
REQ-001 SHALL have parameter NUM_SS, default 5, number of SPI slave selects routed.
REQ-002 SHALL have parameter DATA_W, default 16, SPI command/data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request queue depth (power of two, at least 2).
REQ-004 SHALL have parameter GAP_CYC, default 8, minimum idle clocks between transactions.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit (used only under REQ-027).
REQ-006 SHALL have port clk, input, 1 bit: single clock. One clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-008 SHALL have ports req_vld (input, 1), req_rdy (output, 1), req_ss (input, SSW=$clog2(NUM_SS)) and req_data (input, DATA_W): request channel.
REQ-009 SHALL have ports rsp_vld (output, 1), rsp_ss (output, SSW) and rsp_data (output, DATA_W): response, a one-cycle pulse.
REQ-010 SHALL have ports spi_wrt (output, 1), spi_cmd (output, DATA_W), spi_ss_n (input, 1, master's SS_n), spi_done (input, 1) and spi_rdata (input, DATA_W): SPI master side.
REQ-011 SHALL have ports ss_n (output, NUM_SS, per-slave selects, active low), busy (output, 1) and err (output, 1, sticky).

Function
REQ-012 SHALL accept a request when req_vld and req_rdy are both high on a clk edge; req_rdy = queue not full.
REQ-013 SHALL store {req_ss, req_data} in a FIFO_DEPTH-entry FIFO; simultaneous push and pop when full is permitted and keeps the count constant.
REQ-014 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> GAP -> IDLE.
- IDLE: leave when the queue is not empty.
- LAUNCH: one cycle; pop the head, latch target into sel_q, drive spi_cmd and a one-cycle spi_wrt pulse.
- WAIT: stay until spi_done.
- GAP: count GAP_CYC cycles, then return to IDLE.
REQ-015 SHALL drop a popped entry whose req_ss >= NUM_SS without asserting spi_wrt, set err, and go directly to GAP.
REQ-016 SHALL register spi_ss_n once and drive ss_n[sel_q] = registered spi_ss_n; all other ss_n bits SHALL be 1.
REQ-017 SHALL change sel_q only in LAUNCH, so sel_q never changes while any ss_n bit is low.
REQ-018 SHALL, on spi_done in WAIT, pulse rsp_vld for one cycle on the next cycle, with rsp_ss = sel_q and rsp_data = spi_rdata captured at spi_done.
REQ-019 SHALL give a latency of 2 cycles from a push into an empty IDLE queue to spi_wrt high.
REQ-020 SHALL ignore spi_done outside WAIT.
REQ-021 SHALL drive busy high whenever state != IDLE or the queue is non-empty.
REQ-022 SHALL keep err high until rst.
REQ-023 SHALL drive spi_cmd from a register holding the last launched data.

Reset
REQ-024 SHALL, while rst is high on a clk edge, force the following on that edge:
- state IDLE, queue empty, sel_q 0, gap counter 0;
- spi_wrt 0, spi_cmd 0, rsp_vld 0, rsp_ss 0, rsp_data 0;
- ss_n all 1, busy 0, err 0.
REQ-025 SHALL, when rst is asserted mid-transaction (WAIT), discard the in-flight response, drive all ss_n high on the next edge, and flush the queue.
REQ-026 SHALL drive req_rdy 1 after reset release.

Configuration
REQ-027 SHALL, when macro SPI_SS_SCHED_TIMEOUT_EN is defined, count cycles in WAIT; at TIMEOUT_CYC without spi_done it SHALL set err, emit no response, and go to GAP.
REQ-028 SHALL, without SPI_SS_SCHED_TIMEOUT_EN, wait in WAIT indefinitely and contain no timeout counter logic.

Structure
REQ-029 SHALL place slave-select target constants (SS_EEPROM, SS_CH1, SS_CH2, SS_CH3, SS_TRIGGER) and the FSM state enum in the shared package dso_pkg.
REQ-030 SHALL implement the queue as sub-module ss_req_fifo (parametrised width/depth, synchronous active-high reset).

Verification
REQ-031 SHALL cover a single request: req_ss=2, req_data=16'hA5C3; expected response:
- spi_wrt 2 cycles later with spi_cmd=16'hA5C3;
- ss_n=5'b11011 while spi_ss_n is low;
- after spi_done with spi_rdata=16'h00FF: rsp_vld, rsp_ss=2, rsp_data=16'h00FF.
REQ-032 SHALL cover a back-to-back burst of 5 requests with FIFO_DEPTH=4:
- req_rdy drops after 4 accepted while one is in WAIT;
- all 5 launch in order;
- each launch is at least GAP_CYC=8 cycles after the previous spi_done.
REQ-033 SHALL cover an invalid target req_ss=6 with NUM_SS=5: no spi_wrt, err=1, and the next valid request is still serviced.
REQ-034 SHALL cover rst asserted for 1 cycle during WAIT: next cycle ss_n=5'b11111, queue empty, no rsp_vld even if spi_done arrives.
REQ-035 SHALL cover the timeout, with SPI_SS_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: spi_done withheld -> err=1 after 16 WAIT cycles, FSM proceeds to GAP then IDLE, no rsp_vld.
